// File: rtl/axi_line_fill.sv
// axi_line_fill: fetches one cache line with a single AXI4 INCR read burst
// and hands it to the cache one beat at a time. Each beat is presented as a
// one-cycle mem_data_valid strobe, followed by at least one cycle with the
// strobe low, so the cache never sees back-to-back valids.
//
// Optional feature macro: AXI_LINE_FILL_ERR_EN
//   defined   -> fill_err latches a bad rresp or a misplaced rlast until reset
//   undefined -> fill_err is tied low; rresp and rlast are ignored
//
// state | meaning
// IDLE  | waiting for miss; beat outputs hold the last delivered beat
// ADDR  | read-address channel valid, waiting for arready
// DATA  | rready high, waiting for the next read beat
// PRES  | presenting one beat to the cache (mem_data_valid high)
module axi_line_fill #(
    parameter int LINE_BEATS = 32,
    parameter int AXI_ID     = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        miss,
    input  logic [31:0] cpu_addr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data_in,
    output logic        mem_data_valid,
    output logic        mem_last,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic        fill_err
);

    // A single beat still needs a one-bit counter.
    localparam int CW = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;

    localparam logic [CW-1:0] LAST_BEAT = CW'(LINE_BEATS - 1);
    localparam logic [31:0]   LINE_MASK = ~(32'(LINE_BEATS * 4) - 32'd1);
    localparam logic [7:0]    BURST_LEN = 8'(LINE_BEATS - 1);
    localparam logic [3:0]    ID_VALUE  = 4'(AXI_ID);
    localparam logic [2:0]    SIZE_4B   = 3'b010;
    localparam logic [1:0]    BURST_INC = 2'b01;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        PRES = 2'd3
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [31:0]   base;
    logic          last_beat;

    assign last_beat = (cnt == LAST_BEAT);

    // The AR payload is constant for a fill; araddr is the registered base,
    // which cannot change while ADDR waits for arready.
    assign arid    = ID_VALUE;
    assign araddr  = base;
    assign arlen   = BURST_LEN;
    assign arsize  = SIZE_4B;
    assign arburst = BURST_INC;

    // Fill sequencer: address phase, then alternate DATA/PRES per beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            base           <= '0;
            mem_addr       <= '0;
            mem_data_in    <= '0;
            mem_data_valid <= 1'b0;
            mem_last       <= 1'b0;
            arvalid        <= 1'b0;
            rready         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss) begin
                        base     <= cpu_addr & LINE_MASK;
                        mem_addr <= cpu_addr & LINE_MASK;
                        cnt      <= '0;
                        arvalid  <= 1'b1;
                        state    <= ADDR;
                    end
                end
                ADDR: begin
                    if (arvalid && arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (rvalid && rready) begin
                        mem_data_in    <= rdata;
                        rready         <= 1'b0;
                        mem_data_valid <= 1'b1;
                        mem_last       <= last_beat;
                        state          <= PRES;
                    end
                end
                PRES: begin
                    mem_data_valid <= 1'b0;
                    mem_last       <= 1'b0;
                    if (last_beat) begin
                        state <= IDLE;
                    end else begin
                        // The burst is INCR and never wraps inside the line;
                        // the address simply rolls over at 2^32.
                        cnt      <= cnt + CW'(1);
                        mem_addr <= mem_addr + 32'd4;
                        rready   <= 1'b1;
                        state    <= DATA;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef AXI_LINE_FILL_ERR_EN
    logic fill_err_q;

    // Sticky error: non-OKAY response or rlast out of step with the counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            fill_err_q <= 1'b0;
        end else if (state == DATA && rvalid && rready &&
                     (rresp != 2'b00 || rlast != last_beat)) begin
            fill_err_q <= 1'b1;
        end
    end

    assign fill_err = fill_err_q;
`else
    // Response and rlast are deliberately ignored; the counter alone ends the fill.
    logic unused_resp;
    assign unused_resp = ^{rresp, rlast};
    assign fill_err    = 1'b0;
`endif

endmodule

// File: tb/tb_axi_line_fill.sv
// Directed testbench for axi_line_fill. Inputs change on the falling edge,
// outputs are sampled on the falling edge. Build with or without
// AXI_LINE_FILL_ERR_EN; the expected fill_err follows the same macro.
module tb_axi_line_fill;

    localparam int LINE_BEATS = 32;

`ifdef AXI_LINE_FILL_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        miss;
    logic [31:0] cpu_addr;
    logic [31:0] mem_addr;
    logic [31:0] mem_data_in;
    logic        mem_data_valid;
    logic        mem_last;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic        fill_err;

    int n_tests = 0;
    int n_fail  = 0;
    bit exp_err = 1'b0;

    axi_line_fill #(.LINE_BEATS(LINE_BEATS), .AXI_ID(0)) dut (
        .clk            (clk),
        .reset          (reset),
        .miss           (miss),
        .cpu_addr       (cpu_addr),
        .mem_addr       (mem_addr),
        .mem_data_in    (mem_data_in),
        .mem_data_valid (mem_data_valid),
        .mem_last       (mem_last),
        .arid           (arid),
        .araddr         (araddr),
        .arlen          (arlen),
        .arsize         (arsize),
        .arburst        (arburst),
        .arvalid        (arvalid),
        .arready        (arready),
        .rdata          (rdata),
        .rresp          (rresp),
        .rlast          (rlast),
        .rvalid         (rvalid),
        .rready         (rready),
        .fill_err       (fill_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Assert reset for one edge and check every resettable output.
    task automatic apply_reset(input string tag);
        reset = 1'b1;
        miss  = 1'b0;
        @(negedge clk);
        exp_err = 1'b0;
        check({tag, "_mem_addr"}, mem_addr, 32'h0);
        check({tag, "_mem_data"}, mem_data_in, 32'h0);
        check({tag, "_valid"}, 32'(mem_data_valid), 32'h0);
        check({tag, "_last"}, 32'(mem_last), 32'h0);
        check({tag, "_arvalid"}, 32'(arvalid), 32'h0);
        check({tag, "_rready"}, 32'(rready), 32'h0);
        check({tag, "_fill_err"}, 32'(fill_err), 32'h0);
        reset = 1'b0;
    endtask

    // One line fill. stop_after >= 0 ends the fill (reset expected next)
    // after that many pulses; chain keeps miss high for an immediate refill.
    task automatic do_fill(input logic [31:0] addr, input logic [31:0] exp_base,
                           input int stall, input bit gaps, input logic [31:0] dseed,
                           input int bad_beat, input int stop_after, input bit chain,
                           input int exp_ar_cyc);
        int beats     = 0;
        int cyc       = 0;
        int ar_cycles = 0;
        int first_ar  = -1;
        int first_v   = -1;
        bit prev_v    = 1'b0;
        bit done      = 1'b0;
        miss     = 1'b1;
        cpu_addr = addr;
        arready  = 1'b0;
        rvalid   = 1'b1;
        rdata    = dseed;
        rresp    = (bad_beat == 0) ? 2'b10 : 2'b00;
        rlast    = 1'b0;
        while (!done && cyc < 800) begin
            @(negedge clk);
            cyc++;
            if (arvalid) begin
                ar_cycles++;
                if (first_ar < 0) first_ar = cyc;
                check("araddr", araddr, exp_base);
                check("arlen", 32'(arlen), 32'd31);
                check("arsize", 32'(arsize), 32'd2);
                check("arburst", 32'(arburst), 32'd1);
                check("arid", 32'(arid), 32'd0);
                check("rready_in_addr", 32'(rready), 32'd0);
                arready = (ar_cycles > stall);
            end else begin
                arready = 1'b0;
            end
            if (mem_data_valid) begin
                if (first_v < 0) first_v = cyc;
                if (beats == bad_beat) exp_err = ERR_EN;
                check("back_to_back", 32'(prev_v), 32'd0);
                check("mem_addr", mem_addr, exp_base + 32'(4 * beats));
                check("mem_data", mem_data_in, dseed + 32'(beats));
                check("mem_last", 32'(mem_last), 32'(beats == LINE_BEATS - 1));
                check("rready_in_pres", 32'(rready), 32'd0);
                beats++;
                if (mem_last || beats >= LINE_BEATS) done = 1'b1;
                if (beats == stop_after) begin
                    done  = 1'b1;
                    reset = 1'b1;
                    miss  = 1'b0;
                end
            end else begin
                check("last_without_valid", 32'(mem_last), 32'd0);
            end
            check("fill_err", 32'(fill_err), 32'(exp_err));
            prev_v = mem_data_valid;
            rvalid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            rdata  = dseed + 32'(beats);
            rresp  = (beats == bad_beat) ? 2'b10 : 2'b00;
            rlast  = (beats == LINE_BEATS - 1);
        end
        check("fill_done", 32'(done), 32'd1);
        if (stop_after < 0) begin
            check("beat_count", 32'(beats), 32'(LINE_BEATS));
            check("ar_cycles", 32'(ar_cycles), 32'(stall + 1));
            check("first_ar_cycle", 32'(first_ar), 32'(exp_ar_cyc));
            if (!gaps) check("first_valid_cycle", 32'(first_v), 32'(exp_ar_cyc + stall + 2));
            if (!chain) begin
                miss = 1'b0;
                @(negedge clk);
                check("idle_valid", 32'(mem_data_valid), 32'd0);
                check("idle_last", 32'(mem_last), 32'd0);
                check("idle_arvalid", 32'(arvalid), 32'd0);
                check("idle_rready", 32'(rready), 32'd0);
                check("idle_mem_addr", mem_addr, exp_base + 32'(4 * (LINE_BEATS - 1)));
                check("idle_mem_data", mem_data_in, dseed + 32'(LINE_BEATS - 1));
                check("idle_fill_err", 32'(fill_err), 32'(exp_err));
            end
        end
    endtask

    initial begin
        reset    = 1'b1;
        miss     = 1'b0;
        cpu_addr = 32'h0;
        arready  = 1'b0;
        rdata    = 32'h0;
        rresp    = 2'b00;
        rlast    = 1'b0;
        rvalid   = 1'b0;
        @(negedge clk);
        apply_reset("por");

        // basic fill: line 0x0001_2300, beats 0x..2300..0x..237C
        do_fill(32'h0001_2344, 32'h0001_2300, 0, 1'b0, 32'hA500_0000, -1, -1, 1'b0, 1);
        // address stall of 5 cycles
        do_fill(32'h0000_1004, 32'h0000_1000, 5, 1'b0, 32'h5A00_0000, -1, -1, 1'b0, 1);
        // random rvalid gaps, data equals beat index
        do_fill(32'h8000_00FF, 32'h8000_0080, 0, 1'b1, 32'h0000_0000, -1, -1, 1'b0, 1);
        // SLVERR on beat 5
        do_fill(32'h0000_0040, 32'h0000_0000, 0, 1'b0, 32'h0000_1000, 5, -1, 1'b0, 1);
        // reset after beat index 10 (11 pulses), then a clean fill
        do_fill(32'h1234_5678, 32'h1234_5600, 0, 1'b0, 32'hC000_0000, -1, 11, 1'b0, 1);
        apply_reset("abort");
        do_fill(32'h0000_0200, 32'h0000_0200, 0, 1'b0, 32'h0BAD_0000, -1, -1, 1'b0, 1);
        // back-to-back misses, second line at the top of the address space
        do_fill(32'h0000_3010, 32'h0000_3000, 0, 1'b0, 32'h3000_0000, -1, -1, 1'b1, 1);
        do_fill(32'hFFFF_FF80, 32'hFFFF_FF80, 0, 1'b0, 32'hF000_0000, -1, -1, 1'b0, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_line_fill.md
AXI_LINE_FILL -- requirements
Module: axi_line_fill

Interface
REQ-001 SHALL have parameter LINE_BEATS, default 32: number of 32-bit beats per cache line (128 B).
REQ-002 SHALL have parameter AXI_ID, default 0: constant driven on arid.
REQ-003 SHALL have port clk, input, 1: sole clock, all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1: one clock, reset synchronous and active-high.
REQ-005 SHALL have port miss, input, 1: cache miss request, level, held by cache until the cycle after mem_last.
REQ-006 SHALL have port cpu_addr, input, 32: missing address, sampled when a fill starts.
REQ-007 SHALL have ports mem_addr (output, 32), mem_data_in (output, 32), mem_data_valid (output, 1) and mem_last (output, 1): fill beat address, data, one-cycle valid strobe and final-beat flag to the cache.
REQ-008 SHALL have AXI4 read-address ports arid (output, 4), araddr (output, 32), arlen (output, 8), arsize (output, 3), arburst (output, 2), arvalid (output, 1) and arready (input, 1).
REQ-009 SHALL have AXI4 read-data ports rdata (input, 32), rresp (input, 2), rlast (input, 1), rvalid (input, 1) and rready (output, 1).
REQ-010 SHALL have port fill_err, output, 1: sticky fill error flag (see Configuration).

Function
REQ-011 SHALL implement states IDLE, ADDR, DATA, PRES.
REQ-012 IDLE with miss=1 SHALL register base={cpu_addr[31:7],7'b0}, set mem_addr=base and beat counter=0, and go to ADDR next cycle.
REQ-013 ADDR SHALL drive arvalid=1, araddr=base, arlen=LINE_BEATS-1, arsize=3'b010, arburst=INCR, and hold these stable until arvalid&&arready, then go to DATA.
REQ-014 DATA SHALL drive rready=1; on rvalid&&rready it SHALL register rdata into mem_data_in and go to PRES.
REQ-015 PRES SHALL drive mem_data_valid=1 and rready=0 for exactly one cycle, so valid pulses are never back-to-back.
REQ-016 PRES SHALL assert mem_last together with mem_data_valid only when counter==LINE_BEATS-1, then go to IDLE; otherwise it SHALL go to DATA.
REQ-017 mem_addr SHALL equal base+4*counter throughout a fill and SHALL increment by 4 (mod 2^32, no line wrap) in the cycle after each non-last PRES.
REQ-018 The first mem_data_valid SHALL occur no earlier than 3 cycles after the cycle IDLE samples miss=1.
REQ-019 In IDLE, mem_data_valid, mem_last, arvalid and rready SHALL be 0; mem_data_in and mem_addr SHALL hold their last values.
REQ-020 miss falling outside IDLE SHALL be ignored; the burst SHALL always complete, because AXI bursts are not abortable.
REQ-021 The counter SHALL be 5 bits for LINE_BEATS=32 (clog2 width in general) and SHALL never wrap within a fill.
REQ-022 miss=1 in the IDLE cycle immediately following mem_last SHALL start a new fill; no dead cycle is required.

Reset
REQ-023 reset=1 SHALL force IDLE, counter=0, mem_addr=0, mem_data_in=0, mem_data_valid=0, mem_last=0, arvalid=0, rready=0 and fill_err=0 on the next edge.
REQ-024 Reset mid-fill SHALL abandon the burst; the interconnect and memory SHALL be reset in the same cycle.

Configuration
REQ-025 With macro AXI_LINE_FILL_ERR_EN defined: rresp!=OKAY on any accepted beat, or rlast disagreeing with counter==LINE_BEATS-1, SHALL set fill_err, which stays set until reset; beat data SHALL still be delivered unchanged.
REQ-026 Without AXI_LINE_FILL_ERR_EN: fill_err SHALL be tied 0, and rresp and rlast SHALL be ignored; the counter alone decides mem_last.

Verification
REQ-027 Scenario, basic fill: reset, then miss=1 with cpu_addr=0x0001_2344, arready=1, rvalid=1 always -> araddr=0x0001_2300, arlen=31, 32 pulses with mem_addr 0x0001_2300..0x0001_237C, mem_last on the 32nd pulse only.
REQ-028 Scenario, address stall: arready held low 5 cycles -> arvalid and araddr stable for all 5 cycles, no rready before the handshake.
REQ-029 Scenario, rvalid gaps: random rvalid, data = beat index -> mem_data_in = 0..31 in order, every mem_data_valid exactly 1 cycle wide, never back-to-back.
REQ-030 Scenario, bad response: rresp=SLVERR on beat 5 -> with AXI_LINE_FILL_ERR_EN fill_err=1 from the next cycle until reset; without the macro fill_err=0; all 32 beats delivered in both cases.
REQ-031 Scenario, reset mid-fill: reset=1 after beat 10 -> next cycle IDLE, all outputs 0; a new miss then yields a clean 32-beat fill.
REQ-032 Scenario, back-to-back misses: miss=1 again in the cycle after mem_last with cpu_addr=0xFFFF_FF80 -> new AR issued, mem_addr runs up to 0xFFFF_FFFC with no wrap.
